// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the pipeline and a simple
// request/acknowledge bus. Handles lane steering, byte enables, load
// extension, misalignment detection and a bounded bus wait with abort.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Misaligned,
  output logic        Timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  logic        req_in, in_b, in_h, aligned, accept, in_req;
  logic        lat_b, lat_h, lat_uns;
  logic [3:0]  be_st;
  logic [31:0] wd_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [7:0]  cnt_inc;

  // Request decode and alignment check on the live inputs in IDLE
  always_comb begin
    req_in  = MemRead | MemWrite;
    in_b    = (Funct3[1:0] == 2'b00);
    in_h    = (Funct3[1:0] == 2'b01);
    // Reserved encodings (011, 110, 111) fall into the word branch.
    aligned = in_b | (in_h & ~Addr[0]) | (~in_b & ~in_h & (Addr[1:0] == 2'b00));
    accept  = (state_q == IDLE) & req_in & aligned;
    in_req  = (state_q == REQ);
  end

  // Store lane steering and load extraction from the latched access
  always_comb begin
    lat_b   = (funct3_q[1:0] == 2'b00);
    lat_h   = (funct3_q[1:0] == 2'b01);
    lat_uns = funct3_q[2];
    if (lat_b) begin
      be_st    = 4'b0001 << addr_q[1:0];
      wd_lanes = {4{wdata_q[7:0]}};
    end else if (lat_h) begin
      be_st    = addr_q[1] ? 4'b1100 : 4'b0011;
      wd_lanes = {2{wdata_q[15:0]}};
    end else begin
      be_st    = 4'b1111;
      wd_lanes = wdata_q;
    end
    case (addr_q[1:0])
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (lat_b)      ld_data = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
    else if (lat_h) ld_data = {{16{~lat_uns & ld_half[15]}}, ld_half};
    else            ld_data = bus_rdata;
  end

  // Outputs; Stall and Misaligned are gated by rst_n so reset clears them at once
  always_comb begin
    Stall      = rst_n & (accept | in_req);
    Misaligned = rst_n & (state_q == IDLE) & req_in & ~aligned;
    Timeout    = timeout_q;
    ReadData   = rdata_q;
    bus_req    = in_req;
    bus_we     = in_req & we_q;
    bus_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
    bus_be     = in_req ? (we_q ? be_st : 4'b1111) : '0;
    bus_wdata  = (in_req & we_q) ? wd_lanes : '0;
  end

  // Next-state logic: IDLE -> REQ -> DONE -> IDLE, with wait counter abort
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    cnt_inc   = cnt_q + 8'd1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = REQ;
          addr_d   = Addr;
          funct3_d = Funct3;
          wdata_d  = WriteData;
          we_d     = MemWrite;
          cnt_d    = '0;
        end
      end
      REQ: begin
        // Ack is tested first so an ack on the limiting cycle completes normally.
        if (bus_ack) begin
          if (!we_q) rdata_d = ld_data;
          state_d = DONE;
        end else if (cnt_inc == TO_LIMIT) begin
          cnt_d     = cnt_inc;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum bus wait cycles in REQ before abort; legal range 2..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 MemRead  in  1  load request from Controller.
REQ-005 MemWrite  in  1  store request from Controller.
REQ-006 Funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Addr  in  32  byte address from ALU.
REQ-008 WriteData  in  32  store data (rs2).
REQ-009 Stall  out  1  freezes pipeline while access is outstanding.
REQ-010 ReadData  out  32  aligned, extended load result; valid in DONE.
REQ-011 Misaligned  out  1  one-cycle pulse on misaligned access.
REQ-012 Timeout  out  1  one-cycle pulse on bus abort.
REQ-013 bus_req / bus_we  out  1 / 1  bus request and write strobe.
REQ-014 bus_addr  out  32  word address {Addr[31:2],2'b00}.
REQ-015 bus_wdata / bus_be  out  32 / 4  lane-replicated store data, byte enables.
REQ-016 bus_ack / bus_rdata  in  1 / 32  completion strobe, read word.

Function
REQ-017 FSM states IDLE, REQ, DONE shall be the only states.
REQ-018 IDLE: request = MemRead|MemWrite; both high shall be treated as a write.
REQ-019 IDLE, aligned request: latch Addr, Funct3, WriteData, type; go to REQ; Stall=1 combinationally in the same cycle.
REQ-020 Alignment: H/HU requires Addr[0]=0; W requires Addr[1:0]=00; B/BU always aligned.
REQ-021 IDLE, misaligned request: Misaligned=1 for that cycle, no bus_req, Stall=0, stay IDLE.
REQ-022 Reserved Funct3 (011,110,111) shall be treated as W.
REQ-023 REQ: bus_req=1, bus_addr/bus_we/bus_wdata/bus_be held stable from latched values until ack or abort.
REQ-024 Store lanes: B be=0001<<Addr[1:0], wdata={4{byte}}; H be=0011 or 1100 by Addr[1], wdata={2{half}}; W be=1111; loads be=1111.
REQ-025 REQ with bus_ack=1: capture extracted load data into ReadData, go DONE; bus_req low from next cycle.
REQ-026 Load extract: B/BU lane Addr[1:0] sign/zero-extended; H/HU lane Addr[1] sign/zero-extended; W full word; stores leave ReadData unchanged.
REQ-027 Wait counter: cleared on entry to REQ, +1 per REQ cycle without ack; on reaching TIMEOUT, Timeout=1 one cycle, ReadData=0, go DONE.
REQ-028 Ack in the same cycle as counter reaching TIMEOUT: ack wins, no Timeout pulse.
REQ-029 DONE: Stall=0 for exactly one cycle (pipeline advances), then IDLE unconditionally.
REQ-030 bus_ack in IDLE or DONE shall be ignored.
REQ-031 Minimum access latency: Stall high 2 cycles (IDLE entry cycle + one REQ cycle) for zero-wait ack.

Reset
REQ-032 rst_n=0 forces state IDLE, counter 0, ReadData 0, all outputs 0 immediately, regardless of clk.
REQ-033 Reset during REQ shall drop bus_req asynchronously; the pending access is discarded, not retried.
REQ-034 First request shall be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 LW Addr=0x100, bus_rdata=0x12345678, ack after 3 cycles -> bus_addr=0x100, be=1111, ReadData=0x12345678 in DONE, Stall high 4 cycles.
REQ-036 LB Addr=0x103, bus_rdata=0x80FFFFFF, zero-wait ack -> ReadData=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH Addr=0x202, WriteData=0x0000ABCD -> bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD, bus_we=1.
REQ-038 LW Addr=0x101 -> Misaligned pulse, bus_req never asserted, Stall=0.
REQ-039 LW with bus_ack tied low, TIMEOUT=16 -> Timeout pulse after 16 REQ cycles, ReadData=0, IDLE two cycles later.
REQ-040 rst_n low two cycles into REQ -> bus_req and Stall 0 without clock edge; state IDLE after release.
